// File: rtl/dma_read_master_if.sv
// AXI4 read-address and read-data channels between the DMA read master and its memory slave.
interface dma_read_master_if;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;

    modport master (
        output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready
    );

    modport slave (
        input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready
    );
endinterface

// File: rtl/dma_read_master.sv
// Single-outstanding AXI4 read DMA: splits a beat-count transfer into 4 KB-safe INCR bursts
// and streams the returned 64-bit beats straight through to a ready/valid consumer.
module dma_read_master #(
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              dma_raddr,
    input  logic                     dma_rareq,
    input  logic [15:0]              dma_rsize,
    output logic                     dma_rbusy,
    output logic [63:0]              dma_rdata,
    output logic                     dma_rvalid,
    input  logic                     dma_rready,
    output logic                     rd_error,
    dma_read_master_if.master        m_axi
);

    if (MAX_BURST < 1 || MAX_BURST > 256 || (MAX_BURST & (MAX_BURST - 1)) != 0) begin : g_bad_burst
        $error("MAX_BURST must be a power of two in 1..256");
    end
    if (MAX_OUTSTANDING != 1) begin : g_bad_outstanding
        $error("only one outstanding burst is supported");
    end

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    localparam logic [16:0] MAX_BEATS = 17'(MAX_BURST);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [15:0] remaining_q;
    logic [15:0] rem_dec;
    logic [16:0] page_beats;
    logic [16:0] beats;
    logic [7:0]  burst_len;
    logic        accept;
    logic        beat_hs;

    assign accept     = (state_q == IDLE) && dma_rareq;
    assign dma_rvalid = (state_q == DATA) && m_axi.m_rvalid;
    assign beat_hs    = dma_rvalid && dma_rready;
    assign rem_dec    = remaining_q - 16'd1;

    // Beats left before the next 4 KB page; always at least 1 since the address is 8-byte aligned.
    assign page_beats = 17'd512 - {8'd0, addr_q[11:3]};

    always_comb begin
        beats = MAX_BEATS;
        if ({1'b0, remaining_q} < beats) beats = {1'b0, remaining_q};
        if (page_beats < beats)          beats = page_beats;
    end

    assign burst_len = 8'(beats - 17'd1);

    assign m_axi.m_araddr  = addr_q;
    assign m_axi.m_arlen   = (remaining_q == 16'd0) ? 8'd0 : burst_len;
    assign m_axi.m_arsize  = 3'b011;
    assign m_axi.m_arburst = 2'b01;
    assign m_axi.m_arvalid = (state_q == ADDR);
    assign m_axi.m_rready  = (state_q == DATA) && dma_rready;
    assign dma_rdata       = m_axi.m_rdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: next state defaults to the current state first, so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (dma_rareq) state_d = (dma_rsize == 16'd0) ? DONE : ADDR;
            ADDR: if (m_axi.m_arready) state_d = DATA;
            // The slave's rlast closes the burst; the local beat count only decides what follows.
            DATA: if (beat_hs && m_axi.m_rlast) state_d = (rem_dec != 16'd0) ? ADDR : DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= 32'd0;
            remaining_q <= 16'd0;
            rd_error    <= 1'b0;
            dma_rbusy   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q      <= dma_raddr & ~32'h7;
                remaining_q <= dma_rsize;
                rd_error    <= 1'b0;
                dma_rbusy   <= 1'b1;
            end
            if (beat_hs) begin
                addr_q      <= addr_q + 32'd8;
                remaining_q <= rem_dec;
                if (m_axi.m_rresp != 2'b00) rd_error <= 1'b1;
            end
            if (state_q == DONE) dma_rbusy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_read_master.sv
// Bench for dma_read_master: AXI slave model plus scoreboards of expected AR requests and beats.
module tb_dma_read_master;
    localparam int MAX_BURST = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic        clk;
    logic        rst;
    logic [31:0] dma_raddr;
    logic        dma_rareq;
    logic [15:0] dma_rsize;
    logic        dma_rbusy;
    logic [63:0] dma_rdata;
    logic        dma_rvalid;
    logic        dma_rready;
    logic        rd_error;

    dma_read_master_if axi ();

    dma_read_master #(.MAX_BURST(MAX_BURST), .MAX_OUTSTANDING(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .dma_raddr  (dma_raddr),
        .dma_rareq  (dma_rareq),
        .dma_rsize  (dma_rsize),
        .dma_rbusy  (dma_rbusy),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .dma_rready (dma_rready),
        .rd_error   (rd_error),
        .m_axi      (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    ar_t         exp_ar_q[$];
    logic [63:0] exp_data_q[$];

    int          cyc           = 0;
    int          slv_total     = 0;
    int          err_at        = -1;
    int          last_beat_cyc = 0;
    bit          rready_rand   = 1'b0;
    bit          ar_seen       = 1'b0;
    bit          err_pending   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic expect_ar(input logic [31:0] a, input logic [7:0] len);
        ar_t e;
        e.addr = a;
        e.len  = len;
        exp_ar_q.push_back(e);
    endtask

    task automatic expect_beats(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_data_q.push_back(beat_data(base + 32'(i * 8)));
    endtask

    // AXI slave model and output monitor: observe at negedge, drive at posedge+1.
    initial begin : bus_model
        bit          ar_hs;
        bit          r_hs;
        bit          slv_active;
        logic [31:0] slv_base;
        logic [7:0]  slv_len;
        logic [31:0] ar_addr_s;
        logic [7:0]  ar_len_s;
        int          slv_idx;
        ar_t         e;
        slv_active     = 1'b0;
        slv_base       = '0;
        slv_len        = '0;
        slv_idx        = 0;
        ar_addr_s      = '0;
        ar_len_s       = '0;
        dma_rready     = 1'b1;
        axi.m_arready  = 1'b0;
        axi.m_rvalid   = 1'b0;
        axi.m_rlast    = 1'b0;
        axi.m_rresp    = 2'b00;
        axi.m_rdata    = '0;
        forever begin
            @(negedge clk);
            ar_hs = axi.m_arvalid && axi.m_arready;
            r_hs  = axi.m_rvalid && axi.m_rready;
            if (!rst) begin
                if (axi.m_arvalid) ar_seen = 1'b1;
                if (err_pending) begin
                    check("rd_error_set", rd_error, 1);
                    err_pending = 1'b0;
                end
                if (axi.m_rvalid) begin
                    check("rready_mirror", axi.m_rready, dma_rready);
                    check("rvalid_pass", dma_rvalid, 1);
                end
                if (ar_hs) begin
                    ar_addr_s = axi.m_araddr;
                    ar_len_s  = axi.m_arlen;
                    check("arsize", axi.m_arsize, 3'b011);
                    check("arburst", axi.m_arburst, 2'b01);
                    check("ar_expected", exp_ar_q.size() != 0, 1);
                    if (exp_ar_q.size() != 0) begin
                        e = exp_ar_q.pop_front();
                        check("araddr", axi.m_araddr, e.addr);
                        check("arlen", axi.m_arlen, e.len);
                    end
                end
                if (dma_rvalid && dma_rready) begin
                    check("beat_expected", exp_data_q.size() != 0, 1);
                    if (exp_data_q.size() != 0) check("rdata", dma_rdata, exp_data_q.pop_front());
                    last_beat_cyc = cyc;
                    if (slv_total == err_at) begin
                        check("rd_error_pre", rd_error, 0);
                        err_pending = 1'b1;
                    end
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            dma_rready = rready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rst) begin
                slv_active    = 1'b0;
                slv_idx       = 0;
                axi.m_arready = 1'b0;
                axi.m_rvalid  = 1'b0;
                axi.m_rlast   = 1'b0;
                axi.m_rresp   = 2'b00;
            end else begin
                if (r_hs) begin
                    slv_total++;
                    if (axi.m_rlast) slv_active = 1'b0;
                    else             slv_idx++;
                end
                if (ar_hs) begin
                    slv_active = 1'b1;
                    slv_base   = ar_addr_s;
                    slv_len    = ar_len_s;
                    slv_idx    = 0;
                end
                axi.m_arready = 1'($urandom_range(0, 1));
                if (!(axi.m_rvalid && !r_hs)) begin
                    if (slv_active && $urandom_range(0, 3) != 0) begin
                        axi.m_rvalid = 1'b1;
                        axi.m_rdata  = beat_data(slv_base + 32'(slv_idx * 8));
                        axi.m_rlast  = (slv_idx == int'(slv_len));
                        axi.m_rresp  = (slv_total == err_at) ? 2'b10 : 2'b00;
                    end else begin
                        axi.m_rvalid = 1'b0;
                        axi.m_rlast  = 1'b0;
                        axi.m_rresp  = 2'b00;
                    end
                end
            end
        end
    end

    task automatic start_xfer(input logic [31:0] a, input logic [15:0] s);
        @(posedge clk);
        #1;
        dma_raddr = a;
        dma_rsize = s;
        dma_rareq = 1'b1;
        @(posedge clk);
        #1;
        dma_rareq = 1'b0;
        dma_raddr = 32'hDEAD_BEEF;
        dma_rsize = 16'hFFFF;
        check("busy_rise", dma_rbusy, 1);
        check("err_clear_on_accept", rd_error, 0);
    endtask

    task automatic wait_done(input int budget, output int lat);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!dma_rbusy) begin
                done = 1'b1;
                break;
            end
        end
        check("done_in_time", done, 1);
        lat = cyc - last_beat_cyc;
        check("ar_left", exp_ar_q.size(), 0);
        check("beats_left", exp_data_q.size(), 0);
    endtask

    initial begin : stim
        int  lat;
        int  hi;
        bit  reached;
        rst       = 1'b1;
        dma_rareq = 1'b0;
        dma_raddr = '0;
        dma_rsize = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", dma_rbusy, 0);
        check("rst_rvalid", dma_rvalid, 0);
        check("rst_arvalid", axi.m_arvalid, 0);
        check("rst_rready", axi.m_rready, 0);
        check("rst_rd_error", rd_error, 0);
        check("rst_araddr", axi.m_araddr, 0);
        check("rst_arlen", axi.m_arlen, 0);
        rst = 1'b0;

        // Three bursts, the last one short; busy drops two cycles after the final beat.
        expect_ar(32'h1000_0000, 8'd15);
        expect_ar(32'h1000_0080, 8'd15);
        expect_ar(32'h1000_0100, 8'd7);
        expect_beats(32'h1000_0000, 40);
        start_xfer(32'h1000_0000, 16'd40);
        wait_done(500, lat);
        check("busy_fall_latency", lat, 2);

        // Split at the 4 KB page boundary.
        expect_ar(32'h0000_0FF0, 8'd1);
        expect_ar(32'h0000_1000, 8'd1);
        expect_beats(32'h0000_0FF0, 4);
        start_xfer(32'h0000_0FF0, 16'd4);
        wait_done(200, lat);

        // Low address bits ignored, page split, consumer back-pressure.
        rready_rand = 1'b1;
        expect_ar(32'h2000_0F80, 8'd15);
        expect_ar(32'h2000_1000, 8'd3);
        expect_beats(32'h2000_0F80, 20);
        start_xfer(32'h2000_0F85, 16'd20);
        wait_done(800, lat);
        rready_rand = 1'b0;

        // 32-bit address wrap.
        expect_ar(32'hFFFF_FFF0, 8'd1);
        expect_ar(32'h0000_0000, 8'd1);
        expect_beats(32'hFFFF_FFF0, 4);
        start_xfer(32'hFFFF_FFF0, 16'd4);
        wait_done(200, lat);

        // Zero length: one busy cycle, no AR.
        ar_seen = 1'b0;
        start_xfer(32'h6000_0000, 16'd0);
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dma_rbusy) hi++;
        end
        check("zero_busy_cycles", hi, 1);
        check("zero_no_ar", ar_seen, 0);

        // Error response on the third beat.
        err_at = slv_total + 2;
        expect_ar(32'h3000_0000, 8'd7);
        expect_beats(32'h3000_0000, 8);
        start_xfer(32'h3000_0000, 16'd8);
        wait_done(300, lat);
        check("rd_error_sticky", rd_error, 1);
        err_at = -1;
        expect_ar(32'h3000_1000, 8'd0);
        expect_beats(32'h3000_1000, 1);
        start_xfer(32'h3000_1000, 16'd1);
        wait_done(200, lat);

        // Reset while beat 5 of 16 is in flight.
        expect_ar(32'h4000_0000, 8'd15);
        expect_beats(32'h4000_0000, 16);
        start_xfer(32'h4000_0000, 16'd16);
        reached = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (exp_data_q.size() <= 12) begin
                reached = 1'b1;
                break;
            end
        end
        check("abort_point_reached", reached, 1);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", dma_rbusy, 0);
        check("abort_rvalid", dma_rvalid, 0);
        check("abort_arvalid", axi.m_arvalid, 0);
        check("abort_rready", axi.m_rready, 0);
        check("abort_rd_error", rd_error, 0);
        check("abort_araddr", axi.m_araddr, 0);
        check("abort_arlen", axi.m_arlen, 0);
        exp_ar_q.delete();
        exp_data_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dma_rbusy) hi++;
        end
        check("no_busy_after_abort", hi, 0);
        expect_ar(32'h5000_0008, 8'd2);
        expect_beats(32'h5000_0008, 3);
        start_xfer(32'h5000_000F, 16'd3);
        wait_done(200, lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_read_master.md
DMA_READ_MASTER -- requirements
Module: dma_read_master

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 16, meaning maximum AXI beats per burst (power of two, 1..256).
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 1, meaning AXI read bursts in flight (fixed to 1 in this revision).
REQ-003 The block SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port dma_raddr  input  32  transfer start byte address; bits [2:0] ignored and treated as 0.
REQ-006 The block SHALL have port dma_rareq  input  1  transfer request, sampled only in IDLE.
REQ-007 The block SHALL have port dma_rsize  input  16  transfer length in 64-bit beats.
REQ-008 The block SHALL have port dma_rbusy  output  1  transfer in progress.
REQ-009 The block SHALL have ports dma_rdata output 64, dma_rvalid output 1, dma_rready input 1  beat stream to consumer.
REQ-010 The block SHALL have ports m_araddr out 32, m_arlen out 8, m_arsize out 3, m_arburst out 2, m_arvalid out 1, m_arready in 1  AXI4 read-address channel.
REQ-011 The block SHALL have ports m_rdata in 64, m_rresp in 2, m_rlast in 1, m_rvalid in 1, m_rready out 1  AXI4 read-data channel.
REQ-012 The block SHALL have port rd_error  output  1  sticky: a non-OKAY response was seen in the current or last transfer.

Function
REQ-013 The FSM SHALL have states IDLE, ADDR, DATA, DONE.
REQ-014 In IDLE, dma_rareq=1 SHALL latch the address (bits [2:0] zeroed) and size, clear rd_error, and enter ADDR, or enter DONE directly if dma_rsize=0.
REQ-015 dma_rareq SHALL be ignored outside IDLE.
REQ-016 dma_rbusy SHALL be registered: 1 from the cycle after dma_rareq is accepted through the cycle in DONE, and 0 otherwise.
REQ-017 Burst beats SHALL be min(MAX_BURST, remaining beats, (4096 - addr[11:0])/8), so no burst crosses a 4 KB boundary.
REQ-018 m_arlen SHALL be beats-1; m_arsize SHALL be constant 3'b011; m_arburst SHALL be constant 2'b01 (INCR).
REQ-019 In ADDR, m_arvalid SHALL be 1 and m_araddr/m_arlen SHALL be held stable until m_arready; the handshake SHALL move the FSM to DATA.
REQ-020 In DATA: m_rready = dma_rready; dma_rvalid = m_rvalid; dma_rdata = m_rdata (combinational pass-through, zero latency).
REQ-021 Outside DATA, dma_rvalid and m_rready SHALL be 0.
REQ-022 Each beat handshake (m_rvalid & m_rready) SHALL decrement the 16-bit remaining counter; the address SHALL advance by 8 per beat.
REQ-023 On the beat with m_rlast=1, the FSM SHALL go to ADDR if remaining after decrement > 0, else to DONE.
REQ-024 m_rlast SHALL be used as the burst terminator; the block SHALL NOT rely on its own beat count for this.
REQ-025 DONE SHALL last exactly 1 cycle, then IDLE; a zero-length request therefore gives a one-cycle dma_rbusy pulse and no AR transaction.
REQ-026 m_rresp != 2'b00 on any handshaken beat SHALL set rd_error; the data SHALL still be forwarded and the transfer SHALL complete normally.
REQ-027 Address arithmetic SHALL be 32-bit, wrapping at 2^32 without error.

Reset
REQ-028 Asserting rst SHALL immediately force IDLE with dma_rbusy, dma_rvalid, m_arvalid, m_rready, rd_error = 0, and m_araddr, m_arlen = 0.
REQ-029 Reset mid-transfer SHALL abort the transfer with no dma_rbusy falling edge from the aborted transfer after release; the AXI slave SHALL be reset in the same domain.

Verification
REQ-030 The bench SHALL cover: addr 0x1000_0000, size 40 -> AR (0x1000_0000, arlen 15), (0x1000_0080, 15), (0x1000_0100, 7); 40 dma_rvalid beats in order; dma_rbusy falls 2 cycles after the last beat.
REQ-031 The bench SHALL cover: addr 0x0000_0FF0, size 4 -> AR (0x0FF0, arlen 1) then (0x1000, arlen 1).
REQ-032 The bench SHALL cover: random dma_rready toggling on size 20 -> m_rready mirrors it; all 20 beats delivered once each with no loss or duplicates.
REQ-033 The bench SHALL cover: size 0 -> dma_rbusy high exactly 1 cycle; m_arvalid never asserted.
REQ-034 The bench SHALL cover: m_rresp=2'b10 on beat 3 of size 8 -> rd_error=1 from the next cycle, 8 beats delivered, rd_error cleared on the next accepted dma_rareq.
REQ-035 The bench SHALL cover: rst asserted during the DATA beat 5 of 16 -> outputs 0 in the same cycle; a new request after release starts cleanly at its own address.
